// File: rtl/ysyx_23060042_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with ebreak halt and ack timeouts.
// Optional perf counters are built when CTRL_PERF_EN is defined.
module ysyx_23060042_seq_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_ack,
  output logic             ir_we,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_brk,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_ack,
  output logic             rf_we,
  output logic             pc_we,
  input  logic [31:0]      a0,
  output logic             halted,
  output logic [31:0]      halt_code,
  output logic             err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam int            WW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic [31:0]   code_q, code_d;
  logic          wait_hit;

  // WAIT_MAX of zero disables the timeout entirely; the counter just wraps.
  assign wait_hit = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    err_d   = err_q;
    code_d  = code_q;
    ifu_req = 1'b0;
    ir_we   = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        ifu_req = 1'b1;
        ir_we   = ifu_ack;
        if (ifu_ack) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          code_d  = 32'hDEAD_0001;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_brk) begin
          state_d = S_HALT;
          err_d   = 1'b0;
          code_d  = a0;
        end else if (dec_load && dec_store) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          code_d  = 32'hDEAD_0003;
        end else if (dec_load || dec_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = dec_store;
        if (lsu_ack) begin
          state_d = S_WB;
        end else if (wait_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          code_d  = 32'hDEAD_0002;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = ~dec_store;
        state_d = S_FETCH;
      end
      S_HALT:  halted  = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign state_o   = state_q;
  assign err       = err_q;
  assign halt_code = code_q;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;

  always_comb begin
    cyc_d  = cyc_q;
    inst_d = inst_q;
    if (state_q != S_RESET && state_q != S_HALT) cyc_d = cyc_q + CNT_W'(1);
    if (state_q == S_WB) inst_d = inst_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  end

  assign cyc_cnt  = cyc_q;
  assign inst_cnt = inst_q;
`else
  assign cyc_cnt  = '0;
  assign inst_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060042_seq_ctrl.sv
// Scoreboard bench for ysyx_23060042_seq_ctrl: per-cycle expectations queued by the driver,
// compared at the falling edge. Counter expectations follow CTRL_PERF_EN.
module tb_ysyx_23060042_seq_ctrl;

  localparam logic [2:0] S_RST = 3'd0, S_FE = 3'd1, S_DE = 3'd2, S_EX = 3'd3,
                         S_ME = 3'd4, S_WB = 3'd5, S_HA = 3'd6;
  // flag order: ifu_req ir_we lsu_req lsu_wen rf_we pc_we halted err
  localparam logic [7:0] F_NONE = 8'b0000_0000, F_REQ  = 8'b1000_0000,
                         F_IRWE = 8'b1100_0000, F_LSU  = 8'b0010_0000,
                         F_LSUW = 8'b0011_0000, F_WB   = 8'b0000_1100,
                         F_WBS  = 8'b0000_0100, F_HALT = 8'b0000_0010,
                         F_HERR = 8'b0000_0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_ack = 1'b0, lsu_ack = 1'b0;
  logic        dec_load = 1'b0, dec_store = 1'b0, dec_brk = 1'b0;
  logic [31:0] a0 = '0;
  logic        ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halted, err;
  logic [31:0] halt_code;
  logic [2:0]  state_o;
  logic [63:0] cyc_cnt, inst_cnt;

  ysyx_23060042_seq_ctrl #(.WAIT_MAX(16), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ir_we(ir_we),
    .dec_load(dec_load), .dec_store(dec_store), .dec_brk(dec_brk),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ack(lsu_ack),
    .rf_we(rf_we), .pc_we(pc_we), .a0(a0),
    .halted(halted), .halt_code(halt_code), .err(err), .state_o(state_o),
    .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  fl;
    logic [31:0] code;
    logic [63:0] cyc;
    logic [63:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_cyc   = 0;
  logic [63:0] exp_cyc = '0;
  logic [63:0] exp_inst = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got=%h exp=%h", tag, n_cyc, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge and queue what that cycle must show.
  task automatic step(input logic r, input logic ia, input logic la,
                      input logic [2:0] st, input logic [7:0] fl, input logic [31:0] code);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = r;
    ifu_ack = ia;
    lsu_ack = la;
    if (st == S_RST) begin
      exp_cyc  = '0;
      exp_inst = '0;
    end
    e.st   = st;
    e.fl   = fl;
    e.code = code;
`ifdef CTRL_PERF_EN
    e.cyc  = exp_cyc;
    e.inst = exp_inst;
`else
    e.cyc  = '0;
    e.inst = '0;
`endif
    sb.push_back(e);
    if (st != S_RST && st != S_HA) exp_cyc = exp_cyc + 64'd1;
    if (st == S_WB) exp_inst = exp_inst + 64'd1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cyc++;
      check_eq("state", {61'd0, state_o}, {61'd0, e.st});
      check_eq("flags", {56'd0, ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halted, err},
               {56'd0, e.fl});
      check_eq("halt_code", {32'd0, halt_code}, {32'd0, e.code});
      check_eq("cyc_cnt", cyc_cnt, e.cyc);
      check_eq("inst_cnt", inst_cnt, e.inst);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);

    // ALU op, immediate fetch ack: 4 cycles fetch to fetch
    step(0, 0, 0, S_RST, F_NONE, 0);
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 0, S_WB,  F_WB,   0);
    step(0, 0, 0, S_FE,  F_REQ,  0);

    // load with lsu_ack on the third MEM cycle
    dec_load = 1'b1;
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 0, S_ME,  F_LSU,  0);
    step(0, 0, 0, S_ME,  F_LSU,  0);
    step(0, 0, 1, S_ME,  F_LSU,  0);
    step(0, 0, 0, S_WB,  F_WB,   0);
    step(0, 0, 0, S_FE,  F_REQ,  0);
    dec_load = 1'b0;

    // store: write request, WB without rf_we
    dec_store = 1'b1;
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 1, S_ME,  F_LSUW, 0);
    step(0, 0, 0, S_WB,  F_WBS,  0);
    step(0, 0, 0, S_FE,  F_REQ,  0);
    dec_store = 1'b0;

    // ebreak (with load also set, brk wins), a0=0, sticky for 100 cycles
    dec_brk  = 1'b1;
    dec_load = 1'b1;
    a0       = 32'h0000_0000;
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    for (int i = 0; i < 100; i++) step(0, i[0], 0, S_HA, F_HALT, 0);
    step(1, 0, 0, S_HA,  F_HALT, 0);
    dec_load = 1'b0;
    a0       = 32'h0000_0001;
    step(0, 0, 0, S_RST, F_NONE, 0);
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    for (int i = 0; i < 4; i++) step(0, i[0], 0, S_HA, F_HALT, 32'h1);
    step(1, 0, 0, S_HA,  F_HALT, 32'h1);
    dec_brk = 1'b0;

    // fetch timeout after 16 cycles without ack
    step(0, 0, 0, S_RST, F_NONE, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, S_FE, F_REQ, 0);
    step(0, 0, 0, S_HA,  F_HERR, 32'hDEAD_0001);
    step(0, 1, 0, S_HA,  F_HERR, 32'hDEAD_0001);
    step(1, 0, 0, S_HA,  F_HERR, 32'hDEAD_0001);

    // ack on the 16th fetch cycle beats the timeout
    step(0, 0, 0, S_RST, F_NONE, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, S_FE, F_REQ, 0);
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 0, S_WB,  F_WB,   0);
    step(0, 0, 0, S_FE,  F_REQ,  0);

    // load and store together is an illegal decode
    dec_load  = 1'b1;
    dec_store = 1'b1;
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 0, S_HA,  F_HERR, 32'hDEAD_0003);
    step(1, 0, 0, S_HA,  F_HERR, 32'hDEAD_0003);
    dec_store = 1'b0;

    // memory timeout
    step(0, 0, 0, S_RST, F_NONE, 0);
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, S_ME, F_LSU, 0);
    step(0, 0, 0, S_HA,  F_HERR, 32'hDEAD_0002);
    step(1, 0, 0, S_HA,  F_HERR, 32'hDEAD_0002);

    // reset in the middle of a memory handshake; late ack ignored
    step(0, 0, 0, S_RST, F_NONE, 0);
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 0, S_ME,  F_LSU,  0);
    step(1, 0, 0, S_ME,  F_LSU,  0);
    step(0, 0, 1, S_RST, F_NONE, 0);
    step(0, 0, 0, S_FE,  F_REQ,  0);
    dec_load = 1'b0;
    step(0, 1, 0, S_FE,  F_IRWE, 0);
    step(0, 0, 0, S_DE,  F_NONE, 0);
    step(0, 0, 0, S_EX,  F_NONE, 0);
    step(0, 0, 0, S_WB,  F_WB,   0);
    step(0, 0, 0, S_FE,  F_REQ,  0);

    @(negedge clk);
    @(negedge clk);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
